// File: rtl/sr_decode_stage.sv
// RV32I decode stage between fetch and execute: field extraction, immediate
// selection and illegal-opcode detection, with a valid/ready handshake on both sides.
module sr_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_cmdOp,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_cmdF3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_cmdF7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_immType,
    output logic            out_illegal
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    entry_t             dec;
    entry_t             out_q;
    entry_t             skid_q;
    logic               skid_valid;
    logic               accept;
    logic signed [31:0] imm32;

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.instr = in_instr;
        imm32     = '0;
        if (in_instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                    dec.imm_type = IMM_I;
                    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                7'b0100011: begin
                    dec.imm_type = IMM_S;
                    imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                7'b1100011: begin
                    dec.imm_type = IMM_B;
                    imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec.imm_type = IMM_U;
                    imm32 = {in_instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec.imm_type = IMM_J;
                    imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
                end
                7'b0110011: dec.imm_type = IMM_NONE;
                default:    dec.illegal  = 1'b1;
            endcase
        end
        // signed 32-bit value widens with sign extension for XLEN=64
        dec.imm = XLEN'(imm32);
    end

    assign in_ready = !rst && (SKID_EN ? !skid_valid : (!out_valid || out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // skid holds the older entry, so it refills the output first
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_q <= dec;
            end
        end else if (accept && SKID_EN) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_pc      = out_q.pc;
    assign out_cmdOp   = out_q.instr[6:0];
    assign out_rd      = out_q.instr[11:7];
    assign out_cmdF3   = out_q.instr[14:12];
    assign out_rs1     = out_q.instr[19:15];
    assign out_rs2     = out_q.instr[24:20];
    assign out_cmdF7   = out_q.instr[31:25];
    assign out_imm     = out_q.imm;
    assign out_immType = out_q.imm_type;
    assign out_illegal = out_q.illegal;

endmodule

// File: doc/sr_decode_stage.md
Name: sr_decode_stage

Overview:
- Registered RV32I instruction decode stage with a valid/ready handshake on both sides. It sits between fetch and execute in the pipelined schoolRISCV core.
- Extracts register fields and selects one immediate per opcode, sign-extended to XLEN. Classifies the immediate format and flags illegal opcodes.
- Optional skid buffer gives full throughput with no combinational ready path. Synchronous flush supports branch redirect.

Parameters:
- XLEN, 32, data width of imm and pc outputs (32 or 64); imm sign-extended from instr[31].
- SKID_EN, 1, 1: two-entry output (output register + skid register), in_ready registered; 0: single output register, in_ready = ~out_valid | out_ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous; discard all held entries
- in_valid  in  1  instr/pc valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  pc of entry
- out_cmdOp  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_cmdF3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_cmdF7  out  7  instr[31:25]
- out_imm  out  XLEN  selected immediate
- out_immType  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, skid empty, all out_* data = 0.
  - in_ready=0 while rst is high.
- Flush: at the clock edge with flush=1, out_valid=0 and skid is emptied.
  - An input handshake in the same cycle is dropped.
  - Flush has lower priority than rst.
- Immediate selection by instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I: {sext instr[31], instr[30:20]}.
  - 0100011 → S: {sext, instr[31:25], instr[11:7]}.
  - 1100011 → B: {sext, instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111 → U: {sext instr[31], instr[31:12], 12'b0}; on XLEN=64 bits 63:32 copy instr[31].
  - 1101111 → J: {sext, instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011 → NONE, imm=0.
  - Any other opcode, or instr[1:0]≠2'b11 → illegal=1, immType=NONE, imm=0. Raw fields are still passed through.
- Latency: 1 cycle. An input accepted at edge N appears with out_valid=1 after edge N.
- Handshake:
  - Transfer occurs when valid&&ready at the clock edge.
  - out_* are stable while out_valid=1 && out_ready=0.
  - Entries leave strictly in acceptance order; no loss, no duplication.
- SKID_EN=1:
  - in_ready = ~skid_valid (register output).
  - Accept while the output register is empty or draining → write the output register.
  - Accept while the output register is held → write skid, in_ready falls next cycle.
  - When the output drains and skid is full → skid moves into the output register, skid empties.
  - Sustains 1 instr/cycle when out_ready=1.
- SKID_EN=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - Simultaneous drain and accept reloads the output register in the same edge.
- Simultaneous flush and accept: the flush wins; the stage is empty after the edge.
- Reset mid-stall: all held entries are lost; out_valid=0 the next cycle.

Test Plan:
- Decode addi x1,x2,-1:
  - Stimulus: XLEN=32, in_instr=0xFFF10093, out_ready=1.
  - Response: next cycle out_valid=1, rd=1, rs1=2, cmdF3=0, immType=1, imm=0xFFFFFFFF, illegal=0.
- Branch and jump immediates:
  - beq x0,x0,-4 (0xFE000EE3) → immType=3, imm=0xFFFFFFFC.
  - jal x1,+2048 (0x001000EF) → immType=5, imm=0x00000800, rd=1.
- RV64 sign extension:
  - Stimulus: XLEN=64, lui x5 (0x800002B7).
  - Response: imm=0xFFFFFFFF80000000, immType=4, rd=5.
- Illegal encoding:
  - in_instr=0x00000000 → illegal=1, immType=0, imm=0.
  - in_instr=0x0000007F → illegal=1.
- Backpressure with SKID_EN=1:
  - Stimulus: out_ready=0; present pc=0x100 and then pc=0x104 on consecutive cycles.
  - Response: both accepted; in_ready=0 from the cycle after the 2nd accept; out_pc holds 0x100.
  - Then raise out_ready: 0x100 and 0x104 are delivered on consecutive cycles, in_ready returns to 1.
  - Repeat with SKID_EN=0: 2nd instr is not accepted until out_ready=1.
- Flush and reset:
  - Stimulus: stage holding 2 entries; assert flush together with in_valid.
  - Response: next cycle out_valid=0, in_ready=1, the new instr is dropped.
  - Assert rst during a stall: out_valid=0, in_ready=0 while rst is high, all out_* = 0.
